// File: rtl/data_arb_pkg.sv
// Shared types and constants for the data-port arbiter.
// Optional feature macro: DATA_ARB_RR_EN (round-robin grant).
package data_arb_pkg;

   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned STRB_W      = 4;
   localparam int unsigned SIZE_W      = 3;
   localparam int unsigned BEAT_W      = 3;
   localparam int unsigned BURST_BEATS = 4;

   localparam logic [SIZE_W-1:0] BURST_SIZE = 3'b100;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   typedef struct packed {
      logic              wr;
      logic [SIZE_W-1:0] size;
      logic [ADDR_W-1:0] addr;
      logic [STRB_W-1:0] wstrb;
      logic [DATA_W-1:0] wdata;
   } req_t;

   // Only reads of the burst size return multiple beats; every write gets one response.
   function automatic logic [BEAT_W-1:0] beats_for(input req_t r);
      return (!r.wr && (r.size == BURST_SIZE)) ? BEAT_W'(BURST_BEATS) : BEAT_W'(1);
   endfunction

endpackage

// File: rtl/data_arb_grant.sv
// Combinational winner select between two requesters.
// DATA_ARB_RR_EN selects round-robin on ties; otherwise m0 has fixed priority.
module data_arb_grant (
`ifdef DATA_ARB_RR_EN
   input  logic rr_ptr,
`endif
   input  logic m0_req,
   input  logic m1_req,
   output logic gnt_valid,
   output logic gnt_idx
);

   always_comb begin
      gnt_valid = m0_req | m1_req;
`ifdef DATA_ARB_RR_EN
      if (m0_req && m1_req) gnt_idx = rr_ptr;
      else                  gnt_idx = m1_req & ~m0_req;
`else
      gnt_idx = m1_req & ~m0_req;
`endif
   end

endmodule

// File: rtl/data_req_arbiter.sv
// Two-master arbiter for the single-outstanding data sram-like port of the AXI bridge.
// Optional feature macro: DATA_ARB_RR_EN (round-robin grant instead of m0-first).
module data_req_arbiter
   import data_arb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,

   input  logic              m0_req,
   input  logic              m0_wr,
   input  logic [SIZE_W-1:0] m0_size,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [STRB_W-1:0] m0_wstrb,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_addr_ok,
   output logic              m0_data_ok,
   output logic [DATA_W-1:0] m0_rdata,

   input  logic              m1_req,
   input  logic              m1_wr,
   input  logic [SIZE_W-1:0] m1_size,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [STRB_W-1:0] m1_wstrb,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_addr_ok,
   output logic              m1_data_ok,
   output logic [DATA_W-1:0] m1_rdata,

   output logic              down_req,
   output logic              down_wr,
   output logic [SIZE_W-1:0] down_size,
   output logic [ADDR_W-1:0] down_addr,
   output logic [STRB_W-1:0] down_wstrb,
   output logic [DATA_W-1:0] down_wdata,
   input  logic              down_addr_ok,
   input  logic              down_data_ok,
   input  logic [DATA_W-1:0] down_rdata,

   output logic              busy,
   output logic              owner
);

   state_e            state_q, state_d;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic              owner_q, owner_d;
`ifdef DATA_ARB_RR_EN
   logic              rr_q, rr_d;
`endif

   logic gnt_valid;
   logic gnt_idx;
   logic handshake;
   logic beat_fire;
   req_t m0_pl, m1_pl, sel_pl, down_pl;

   data_arb_grant u_grant (
`ifdef DATA_ARB_RR_EN
      .rr_ptr    (rr_q),
`endif
      .m0_req    (m0_req),
      .m1_req    (m1_req),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   always_comb begin
      m0_pl  = '{wr: m0_wr, size: m0_size, addr: m0_addr, wstrb: m0_wstrb, wdata: m0_wdata};
      m1_pl  = '{wr: m1_wr, size: m1_size, addr: m1_addr, wstrb: m1_wstrb, wdata: m1_wdata};
      sel_pl = gnt_idx ? m1_pl : m0_pl;
   end

   // Every output is held at zero while reset is asserted, including the pass-through paths.
   assign down_req  = !reset && (state_q == IDLE) && gnt_valid;
   assign handshake = down_req && down_addr_ok;
   assign beat_fire = !reset && (state_q == WAIT) && down_data_ok;
   assign down_pl   = down_req ? sel_pl : '0;

   assign down_wr    = down_pl.wr;
   assign down_size  = down_pl.size;
   assign down_addr  = down_pl.addr;
   assign down_wstrb = down_pl.wstrb;
   assign down_wdata = down_pl.wdata;

   assign m0_addr_ok = handshake && !gnt_idx;
   assign m1_addr_ok = handshake &&  gnt_idx;
   assign m0_data_ok = beat_fire && !owner_q;
   assign m1_data_ok = beat_fire &&  owner_q;
   assign m0_rdata   = reset ? '0 : down_rdata;
   assign m1_rdata   = reset ? '0 : down_rdata;

   assign busy  = (state_q == WAIT);
   assign owner = owner_q;

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      owner_d    = owner_q;
`ifdef DATA_ARB_RR_EN
      rr_d       = rr_q;
`endif
      case (state_q)
         IDLE: begin
            if (handshake) begin
               owner_d    = gnt_idx;
               beat_cnt_d = beats_for(sel_pl);
               state_d    = WAIT;
`ifdef DATA_ARB_RR_EN
               rr_d       = !gnt_idx;
`endif
            end
         end
         WAIT: begin
            // A data_ok outside WAIT never reaches here, so stray beats are dropped.
            if (down_data_ok) begin
               beat_cnt_d = beat_cnt_q - BEAT_W'(1);
               if (beat_cnt_q == BEAT_W'(1)) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         beat_cnt_q <= '0;
         owner_q    <= 1'b0;
`ifdef DATA_ARB_RR_EN
         rr_q       <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         owner_q    <= owner_d;
`ifdef DATA_ARB_RR_EN
         rr_q       <= rr_d;
`endif
      end
   end

endmodule

// File: tb/tb_data_req_arbiter.sv
// Directed bench for data_req_arbiter with a zero-latency scoreboard of grants and data beats.
// Honours DATA_ARB_RR_EN to select the expected grant order.
module tb_data_req_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_wr, m1_req, m1_wr;
   logic [2:0]  m0_size, m1_size, down_size;
   logic [31:0] m0_addr, m1_addr, down_addr;
   logic [3:0]  m0_wstrb, m1_wstrb, down_wstrb;
   logic [31:0] m0_wdata, m1_wdata, down_wdata;
   logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
   logic [31:0] m0_rdata, m1_rdata, down_rdata;
   logic        down_req, down_wr, down_addr_ok, down_data_ok;
   logic        busy, owner;

   typedef struct {
      logic        idx;
      logic [31:0] data;
   } dat_t;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic        exp_gnt_q[$];
   dat_t        exp_dat_q[$];

   always #5 clk = ~clk;

   data_req_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
      .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata),
      .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
      .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata),
      .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
      .down_req(down_req), .down_wr(down_wr), .down_size(down_size), .down_addr(down_addr),
      .down_wstrb(down_wstrb), .down_wdata(down_wdata),
      .down_addr_ok(down_addr_ok), .down_data_ok(down_data_ok), .down_rdata(down_rdata),
      .busy(busy), .owner(owner)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_gnt(input logic idx);
      exp_gnt_q.push_back(idx);
   endtask

   task automatic push_dat(input logic idx, input logic [31:0] data);
      dat_t d;
      d.idx  = idx;
      d.data = data;
      exp_dat_q.push_back(d);
   endtask

   // Expectations are due in the cycle they were pushed; anything left over is a miss.
   task automatic monitor();
      logic [1:0] aok, dok;
      logic       g;
      dat_t       d;
      aok = {m1_addr_ok, m0_addr_ok};
      dok = {m1_data_ok, m0_data_ok};
      if (exp_gnt_q.size() != 0) begin
         g = exp_gnt_q.pop_front();
         chk("grant_addr_ok", 32'(aok), g ? 32'h2 : 32'h1);
      end else if (aok != 2'b00) begin
         chk("spurious_addr_ok", 32'(aok), 32'h0);
      end
      if (exp_dat_q.size() != 0) begin
         d = exp_dat_q.pop_front();
         chk("data_ok_route", 32'(dok), d.idx ? 32'h2 : 32'h1);
         chk("rdata", d.idx ? m1_rdata : m0_rdata, d.data);
      end else if (dok != 2'b00) begin
         chk("spurious_data_ok", 32'(dok), 32'h0);
      end
   endtask

   task automatic settle();
      @(negedge clk);
      monitor();
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      settle();
      adv();
   endtask

   task automatic clear_inputs();
      m0_req = 0; m0_wr = 0; m0_size = 3'd2; m0_addr = '0; m0_wstrb = '0; m0_wdata = '0;
      m1_req = 0; m1_wr = 0; m1_size = 3'd2; m1_addr = '0; m1_wstrb = '0; m1_wdata = '0;
      down_addr_ok = 0; down_data_ok = 0; down_rdata = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic exp_idx;
      clear_inputs();

      // Reset holds every output low even with live inputs.
      reset = 1; m0_req = 1; down_addr_ok = 1; down_data_ok = 1; down_rdata = 32'hA5A5_A5A5;
      settle();
      chk("rst_down_req", 32'(down_req), 32'h0);
      chk("rst_m0_addr_ok", 32'(m0_addr_ok), 32'h0);
      chk("rst_m0_rdata", m0_rdata, 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_owner", 32'(owner), 32'h0);
      adv();
      clear_inputs();
      reset = 0;
      cyc();

      // m0 single read with a slow downstream accept.
      m0_req = 1; m0_addr = 32'h1FC0_0000; m0_size = 3'd2;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("t1_down_req_held", 32'(down_req), 32'h1);
         chk("t1_down_addr_held", down_addr, 32'h1FC0_0000);
         chk("t1_no_addr_ok", 32'(m0_addr_ok), 32'h0);
         adv();
      end
      down_addr_ok = 1; push_gnt(1'b0);
      settle();
      chk("t1_down_size", 32'(down_size), 32'h2);
      adv();
      m0_req = 0; down_addr_ok = 0;
      settle();
      chk("t1_busy", 32'(busy), 32'h1);
      chk("t1_down_req_wait", 32'(down_req), 32'h0);
      adv();
      down_data_ok = 1; down_rdata = 32'hDEAD_BEEF; push_dat(1'b0, 32'hDEAD_BEEF);
      settle();
      chk("t1_busy_last_beat", 32'(busy), 32'h1);
      adv();
      down_data_ok = 0;
      settle();
      chk("t1_busy_after", 32'(busy), 32'h0);
      adv();

      // m1 burst read with gapped beats while m0 waits and the bridge keeps accepting.
      m1_req = 1; m1_addr = 32'h8000_0040; m1_size = 3'b100; down_addr_ok = 1; push_gnt(1'b1);
      settle();
      chk("t2_down_size", 32'(down_size), 32'h4);
      chk("t2_down_addr", down_addr, 32'h8000_0040);
      adv();
      m1_req = 0; m0_req = 1; m0_addr = 32'h0000_1000;
      for (int i = 0; i < 7; i++) begin
         down_data_ok = (i % 2 == 0);
         down_rdata   = 32'h1000 + 32'(i);
         if (down_data_ok) push_dat(1'b1, 32'h1000 + 32'(i));
         settle();
         chk("t2_busy", 32'(busy), 32'h1);
         chk("t2_no_down_req", 32'(down_req), 32'h0);
         if (i == 2) chk("t2_m0_rdata_bcast", m0_rdata, 32'h1002);
         adv();
      end
      down_data_ok = 0; push_gnt(1'b0);
      settle();
      chk("t2_idle_after_4th", 32'(busy), 32'h0);
      adv();
      m0_req = 0; down_addr_ok = 0; down_data_ok = 1; down_rdata = 32'h55; push_dat(1'b0, 32'h55);
      cyc();
      down_data_ok = 0;
      cyc();

      // Contention: both masters request every cycle from a fresh reset.
      reset = 1;
      cyc();
      reset = 0;
      m1_size = 3'd2; m0_addr = 32'h0000_2000; m1_addr = 32'h0000_3000;
      for (int t = 0; t < 4; t++) begin
`ifdef DATA_ARB_RR_EN
         exp_idx = 1'(t % 2);
`else
         exp_idx = 1'b0;
`endif
         m0_req = 1; m1_req = 1; down_addr_ok = 1; push_gnt(exp_idx);
         settle();
         chk("t3_down_addr", down_addr, exp_idx ? 32'h0000_3000 : 32'h0000_2000);
         adv();
         down_addr_ok = 0; down_data_ok = 1; down_rdata = 32'h300 + 32'(t);
         push_dat(exp_idx, 32'h300 + 32'(t));
         settle();
         chk("t3_owner", 32'(owner), 32'(exp_idx));
         adv();
         down_data_ok = 0;
      end
      m0_req = 0; m1_req = 0;
      cyc();

      // m1 write (burst size code, still one response); m0 raised during WAIT.
      m1_req = 1; m1_wr = 1; m1_size = 3'b100; m1_addr = 32'h1FAF_0010;
      m1_wstrb = 4'b0011; m1_wdata = 32'h1234_5678; down_addr_ok = 1; push_gnt(1'b1);
      settle();
      chk("t4_down_wr", 32'(down_wr), 32'h1);
      chk("t4_down_wstrb", 32'(down_wstrb), 32'h3);
      chk("t4_down_wdata", down_wdata, 32'h1234_5678);
      chk("t4_down_addr", down_addr, 32'h1FAF_0010);
      adv();
      m1_req = 0; m0_req = 1; m0_wr = 0; m0_addr = 32'h0000_4000;
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("t4_m0_blocked", 32'(m0_addr_ok), 32'h0);
         adv();
      end
      down_data_ok = 1; down_rdata = 32'h0; push_dat(1'b1, 32'h0);
      settle();
      chk("t4_no_b2b_issue", 32'(down_req), 32'h0);
      adv();
      down_data_ok = 0; push_gnt(1'b0);
      settle();
      chk("t4_write_one_resp", 32'(busy), 32'h0);
      adv();
      m0_req = 0; down_addr_ok = 0; down_data_ok = 1; down_rdata = 32'h77; push_dat(1'b0, 32'h77);
      cyc();
      down_data_ok = 0;
      cyc();

      // Reset in the middle of an m1 transaction, then a stray beat.
      m1_req = 1; m1_wr = 0; m1_size = 3'd2; down_addr_ok = 1; push_gnt(1'b1);
      cyc();
      m1_req = 0; down_addr_ok = 0;
      settle();
      chk("t5_busy_before_rst", 32'(busy), 32'h1);
      chk("t5_owner_m1", 32'(owner), 32'h1);
      adv();
      reset = 1;
      settle();
      chk("t5_rst_busy", 32'(busy), 32'h0);
      chk("t5_rst_owner", 32'(owner), 32'h0);
      adv();
      reset = 0; down_data_ok = 1; down_rdata = 32'hBAD0_BAD0;
      settle();
      chk("t5_stray_m0", 32'(m0_data_ok), 32'h0);
      chk("t5_stray_m1", 32'(m1_data_ok), 32'h0);
      chk("t5_stray_busy", 32'(busy), 32'h0);
      adv();
      down_data_ok = 0; m0_req = 1; down_addr_ok = 1; push_gnt(1'b0);
      settle();
      chk("t5_regrant", 32'(down_req), 32'h1);
      adv();
      m0_req = 0; down_addr_ok = 0; down_data_ok = 1; down_rdata = 32'hCAFE_F00D;
      push_dat(1'b0, 32'hCAFE_F00D);
      cyc();
      down_data_ok = 0;
      cyc();

      // A request raised in the completion cycle waits one cycle.
      m0_req = 1; down_addr_ok = 1; push_gnt(1'b0);
      cyc();
      m0_req = 0; down_addr_ok = 0;
      cyc();
      down_data_ok = 1; down_rdata = 32'h9; push_dat(1'b0, 32'h9);
      m0_req = 1; m0_addr = 32'h0000_5000; down_addr_ok = 1;
      settle();
      chk("t6_not_same_cycle", 32'(down_req), 32'h0);
      adv();
      down_data_ok = 0; push_gnt(1'b0);
      settle();
      chk("t6_next_cycle_addr", down_addr, 32'h0000_5000);
      adv();
      m0_req = 0; down_addr_ok = 0; down_data_ok = 1; down_rdata = 32'hA; push_dat(1'b0, 32'hA);
      cyc();
      down_data_ok = 0;
      cyc();

      chk("sb_grants_drained", 32'(exp_gnt_q.size()), 32'h0);
      chk("sb_data_drained", 32'(exp_dat_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
